cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single external memory port between I-cache miss refills and D-cache miss refills/write-backs.
- Raises the pipeline-wide stall while any cache is waiting on memory.
- Sits between both cache controllers and the memory model; its stall output feeds the fetch stage and the hazard logic.

Parameters:
ADDR_W, 28, block address width (word address with the low 2 bits of the block offset dropped)
DATA_W, 128, block width in bits (4 words)
TIMEOUT, 255, maximum cycles to wait for mem_ready before aborting; must be at least 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ic_req  input  1  I-cache miss request; held high until ic_ready
ic_addr  input  ADDR_W  I-cache block address; stable while ic_req is high
ic_ready  output  1  one-cycle pulse: ic_rdata valid
ic_rdata  output  DATA_W  refill block for the I-cache
dc_req  input  1  D-cache request; held high until dc_ready
dc_wr  input  1  1 = write-back, 0 = refill; stable while dc_req is high
dc_addr  input  ADDR_W  D-cache block address
dc_wdata  input  DATA_W  write-back block
dc_ready  output  1  one-cycle pulse: transaction complete
dc_rdata  output  DATA_W  refill block for the D-cache
mem_req  output  1  memory request, level-held until mem_ready
mem_wr  output  1  memory write enable
mem_addr  output  ADDR_W  memory block address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion, sampled only while mem_req is high
stall  output  1  (ic_req & ~ic_ready) | (dc_req & ~dc_ready), combinational
err_timeout  output  1  sticky timeout flag

Behaviour:
- States: IDLE, MEM_I, MEM_D, RESP_I, RESP_D. Every register updates on the posedge of clk.
- Reset (rst=1 at an edge): state=IDLE, last_grant=I, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, ic_rdata=0, dc_rdata=0, ic_ready=0, dc_ready=0, err_timeout=0, wait counter=0. stall follows its equation.
- Reset mid-transaction abandons the memory access: mem_req is low from the next cycle, and no ready pulse is issued.
- IDLE arbitration:
  - Only ic_req high: go to MEM_I.
  - Only dc_req high: go to MEM_D.
  - Both high: grant the requester that is not last_grant (round-robin). The first conflict after reset therefore goes to D.
  - On grant: latch mem_addr and mem_wr (0 for I, dc_wr for D), latch mem_wdata (dc_wdata for D, 0 for I), set mem_req=1, update last_grant, clear the counter.
- MEM_x: mem_req stays high and mem_addr/mem_wr/mem_wdata stay frozen.
  - mem_ready=1: capture mem_rdata into x_rdata (D writes leave dc_rdata unchanged), set mem_req=0, go to RESP_x.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with no mem_ready: set err_timeout=1, x_rdata=0, mem_req=0, go to RESP_x.
- RESP_x: x_ready=1 for exactly one cycle, then IDLE.
- Requester rule: a requester drops req, or presents a new transaction, in the cycle after its ready. A request seen in IDLE is always a new one.
- Minimum latency: req sampled at edge 0 -> mem_req high after edge 0 -> mem_ready in that cycle -> ready high after edge 1 (ready two edges after req first sampled).
- A request arriving while the other requester is served waits. stall stays high for both requesters.
- No back-to-back grant without passing through IDLE. Worst-case fairness is one transaction of waiting.
- mem_ready outside a MEM state is ignored.
- err_timeout clears only on rst.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=3'd0, MEM_I=3'd1, MEM_D=3'd2, RESP_I=3'd3, RESP_D=3'd4)
  - grant ids (GRANT_I=1'b0, GRANT_D=1'b1)
  - default ADDR_W/DATA_W
- Single module: the FSM, the round-robin bit and the wait counter are small. No sub-module is needed.

Test Plan:
- Single I miss, ic_addr=28'h0000040, memory answers mem_ready 3 cycles after mem_req with mem_rdata=128'hDEADBEEF_0000_0001_0000_0002_0000_0003 -> mem_addr=28'h0000040, mem_wr=0; ic_ready pulses once with that data; stall high from req until the ready cycle.
- ic_req and dc_req rise together after reset (dc_wr=0, dc_addr=28'h0000100), repeated twice -> first grant D, then I. The second simultaneous pair grants D again; the order strictly alternates.
- D write-back, dc_wr=1, dc_wdata=128'h1234..., memory answers immediately -> mem_wr=1, mem_wdata matches dc_wdata, dc_ready exactly 2 edges after dc_req is sampled, dc_rdata unchanged.
- Memory never asserts mem_ready, TIMEOUT=8 -> after 8 counted cycles err_timeout=1 and ic_ready pulses with ic_rdata=0. err_timeout stays 1 through later good transactions until rst.
- rst asserted in MEM_D after 2 wait cycles -> next cycle mem_req=0, state IDLE, no dc_ready pulse. After rst drops, a held dc_req is re-arbitrated and served normally.
- mem_ready pulsed while IDLE, and ic_req dropped at the cycle after ic_ready -> no spurious ready pulse, no extra grant.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, grant ids and
// default bus widths.
package cache_mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_DATA_W = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MEM_I  = 3'd1,
        MEM_D  = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and memory.
// The arbiter uses the slave view; the environment driving it uses master.
interface cache_mem_arbiter_if #(
    parameter int unsigned ADDR_W = cache_mem_arbiter_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = cache_mem_arbiter_pkg::DEF_DATA_W
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [DATA_W-1:0] ic_rdata;

    logic              dc_req;
    logic              dc_wr;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [DATA_W-1:0] dc_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall;
    logic              err_timeout;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata,
               mem_rdata, mem_ready,
        output ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_req, mem_wr, mem_addr, mem_wdata, stall, err_timeout
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata,
               mem_rdata, mem_ready,
        input  ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_req, mem_wr, mem_addr, mem_wdata, stall, err_timeout
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/write-backs, with a bounded wait and a pipeline stall.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q,     state_d;
    grant_e            last_q,      last_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ic_rdata_q,  ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q,  dc_rdata_d;
    logic              ic_ready_q,  ic_ready_d;
    logic              dc_ready_q,  dc_ready_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic grant_d_side;
    logic serving_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= GRANT_I;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // On a conflict D wins unless it was the last one served.
    assign grant_d_side = bus.dc_req && (!bus.ic_req || (last_q == GRANT_I));
    assign serving_i    = (state_q == MEM_I);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        ic_ready_d  = 1'b0;
        dc_ready_d  = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    if (grant_d_side) begin
                        state_d     = MEM_D;
                        last_d      = GRANT_D;
                        mem_wr_d    = bus.dc_wr;
                        mem_addr_d  = bus.dc_addr;
                        mem_wdata_d = bus.dc_wdata;
                    end else begin
                        state_d     = MEM_I;
                        last_d      = GRANT_I;
                        mem_wr_d    = 1'b0;
                        mem_addr_d  = bus.ic_addr;
                        mem_wdata_d = '0;
                    end
                end
            end

            MEM_I, MEM_D: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    if (serving_i) begin
                        ic_rdata_d = bus.mem_rdata;
                    end else if (!mem_wr_q) begin
                        dc_rdata_d = bus.mem_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: the requester still gets its ready, with zeroed data.
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (serving_i) begin
                        ic_rdata_d = '0;
                    end else begin
                        dc_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (!mem_req_d) begin
                    state_d    = serving_i ? RESP_I : RESP_D;
                    ic_ready_d = serving_i;
                    dc_ready_d = !serving_i;
                end
            end

            RESP_I, RESP_D: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.ic_rdata    = ic_rdata_q;
    assign bus.dc_rdata    = dc_rdata_q;
    assign bus.ic_ready    = ic_ready_q;
    assign bus.dc_ready    = dc_ready_q;
    assign bus.err_timeout = err_q;
    assign bus.stall       = (bus.ic_req & ~ic_ready_q) | (bus.dc_req & ~dc_ready_q);

endmodule
